// File: rtl/decodificador_hamming.sv
// Hamming(7,4) decoder: two-stage valid/ready pipeline that corrects single-bit errors
// and keeps a saturating count of corrected words handed to the consumer.
module decodificador_hamming #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           codeword,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           data_out,
  output logic [2:0]           syndrome,
  output logic                 err_corr,
  input  logic                 cnt_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Handshake: a word moves on a rising edge only when valid && ready are both high
  // on that edge; the producer holds the word stable until it is taken. in_ready
  // depends combinationally on out_ready, so a stalled output backs up instantly.

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic                 r_s1_valid;
  logic [6:0]           r_s1_cw;
  logic                 r_out_valid;
  logic [3:0]           r_data;
  logic [2:0]           r_syn;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_cnt;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic [2:0]           w_syn;
  logic [6:0]           w_fixed;
  logic                 w_out_hs;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_out_hs = r_out_valid && out_ready;

  // Syndrome bits check positions whose index has that bit set (c1..c7 = cw[0..6]).
  always_comb begin
    w_syn[0] = r_s1_cw[0] ^ r_s1_cw[2] ^ r_s1_cw[4] ^ r_s1_cw[6];
    w_syn[1] = r_s1_cw[1] ^ r_s1_cw[2] ^ r_s1_cw[5] ^ r_s1_cw[6];
    w_syn[2] = r_s1_cw[3] ^ r_s1_cw[4] ^ r_s1_cw[5] ^ r_s1_cw[6];
  end

  always_comb begin
    w_fixed = r_s1_cw;
    for (int i = 0; i < 7; i++) begin
      if (w_syn == 3'(i + 1)) begin
        w_fixed[i] = ~r_s1_cw[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_cw <= codeword;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_syn       <= '0;
      r_err       <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data <= {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
        r_syn  <= w_syn;
        r_err  <= (w_syn != 3'd0);
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_out_hs && r_err && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_out_valid;
  assign data_out  = r_data;
  assign syndrome  = r_syn;
  assign err_corr  = r_err;
  assign err_count = r_cnt;

endmodule

// File: tb/tb_decodificador_hamming.sv
// Bench for decodificador_hamming: directed cases plus random traffic with backpressure,
// scored against a position-XOR Hamming reference model and an expected-data queue.
module tb_decodificador_hamming;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [6:0] codeword;
  logic       out_ready;
  logic       cnt_clr;

  logic       in_ready,  in_ready2;
  logic       out_valid, out_valid2;
  logic [3:0] data_out,  data_out2;
  logic [2:0] syndrome,  syndrome2;
  logic       err_corr,  err_corr2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];
  int         cnt8 = 0;
  int         cnt2 = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_out;

  decodificador_hamming #(.ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .codeword(codeword), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .syndrome(syndrome), .err_corr(err_corr),
    .cnt_clr(cnt_clr), .err_count(err_count)
  );

  decodificador_hamming #(.ERR_CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .codeword(codeword), .out_valid(out_valid2), .out_ready(out_ready),
    .data_out(data_out2), .syndrome(syndrome2), .err_corr(err_corr2),
    .cnt_clr(cnt_clr), .err_count(err_count2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // The syndrome of a Hamming(7,4) word is the XOR of the positions holding a 1.
  function automatic logic [7:0] ref_decode(input logic [6:0] cw);
    int         s;
    logic [6:0] f;
    s = 0;
    for (int i = 0; i < 7; i++) if (cw[i]) s = s ^ (i + 1);
    f = cw;
    if (s != 0) f[s-1] = ~f[s-1];
    return {f[6], f[5], f[4], f[2], 3'(s), (s != 0)};
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    logic       exp_rdy;
    cyc++;
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_syndrome", syndrome, 0);
      check("rst_err_corr", err_corr, 0);
      check("rst_err_count", err_count, 0);
      check("rst_err_count_w2", err_count2, 0);
      exp_q.delete();
      cnt8 = 0;
      cnt2 = 0;
      stall_prev = 1'b0;
    end else begin
      exp_rdy = !(exp_q.size() == 2 && !out_ready);
      check("in_ready", in_ready, exp_rdy);
      check("in_ready_w2", in_ready2, exp_rdy);
      check("err_count", err_count, cnt8);
      check("err_count_w2", err_count2, cnt2);
      if (stall_prev) begin
        check("stall_out_valid", out_valid, 1);
        check("stall_hold", {data_out, syndrome, err_corr}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_valid, 0);
          e = 8'h00;
        end else begin
          e = exp_q.pop_front();
          check("data_out", data_out, e[7:4]);
          check("syndrome", syndrome, e[3:1]);
          check("err_corr", err_corr, e[0]);
          check("data_out_w2", {out_valid2, data_out2, syndrome2, err_corr2}, {1'b1, e});
        end
      end else begin
        e = 8'h00;
      end
      if (cnt_clr) begin
        cnt8 = 0;
        cnt2 = 0;
      end else if (out_valid && out_ready && e[0]) begin
        if (cnt8 < 255) cnt8++;
        if (cnt2 < 3) cnt2++;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_decode(codeword));
      stall_prev = out_valid && !out_ready;
      prev_out   = {data_out, syndrome, err_corr};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [6:0] cw);
    int n;
    n = 0;
    in_valid = 1'b1;
    codeword = cw;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  // Expects an empty pipeline and out_ready high; checks the 2-cycle latency and result.
  task automatic send_latency(input logic [6:0] cw, input logic [7:0] exp_res);
    send(cw);
    @(negedge clk);
    check("lat_not_early", out_valid, 0);
    @(negedge clk);
    check("lat_valid_2cyc", out_valid, 1);
    check("lat_result", {data_out, syndrome, err_corr}, exp_res);
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    codeword  = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean word, then the same word with c3 flipped.
    send_latency(7'h55, {4'b1011, 3'd0, 1'b0});
    send_latency(7'h51, {4'b1011, 3'd3, 1'b1});
    @(negedge clk);
    check("err_count_after_one", err_count, 1);
    @(posedge clk); #1;

    // Every data word with every single-bit flip.
    pulse_clr();
    for (int d = 0; d < 16; d++) begin
      for (int b = 0; b < 7; b++) begin
        send(encode(4'(d)) ^ (7'd1 << b));
      end
    end
    drain();
    @(negedge clk);
    check("err_count_112", err_count, 112);
    check("err_count_w2_sat", err_count2, 3);
    @(posedge clk); #1;

    // Three words back to back with a 3-cycle stall on the first result.
    fork
      begin
        send(7'h00);
        send(7'h7F);
        send(7'h55);
      end
      begin
        wait_out_valid();
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready_low", in_ready, 0);
        check("stall_first_word", data_out, 4'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Saturation of the narrow counter, then clear racing an error handshake.
    pulse_clr();
    for (int k = 0; k < 5; k++) send(encode(4'($urandom_range(0, 15))) ^ (7'd1 << $urandom_range(0, 6)));
    drain();
    @(negedge clk);
    check("w2_sticks_at_3", err_count2, 3);
    check("w8_counts_5", err_count, 5);
    @(posedge clk); #1;
    send(7'h51);
    wait_out_valid();
    pulse_clr();
    @(negedge clk);
    check("clr_beats_inc", err_count, 0);
    check("clr_beats_inc_w2", err_count2, 0);
    @(posedge clk); #1;
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(7'h7F);
    send(7'h00);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_err_count", err_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_latency(7'h51, {4'b1011, 3'd3, 1'b1});

    // Random traffic with random backpressure and occasional clears.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        codeword = 7'($urandom_range(0, 127));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk); #1;
    if (!acc && in_valid) begin
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      send(codeword);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    drain();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
